// File: rtl/channel_rx_fifo_if.sv
// rtl/channel_rx_fifo_if.sv - channel and local-port signal bundle for channel_rx_fifo
interface channel_rx_fifo_if #(
  parameter int N                   = 10,
  parameter int LATENCY_COUNT_WIDTH = 6
);
  logic                           in_valid;
  logic [N-1:0]                   in_data;
  logic                           in_ready;
  logic [LATENCY_COUNT_WIDTH-1:0] in_latency;
  logic                           out_valid;
  logic [N-1:0]                   out_data;
  logic                           out_ready;
  logic                           proto_err;

  // Environment side: sender plus local consumer.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, in_latency, out_valid, out_data, proto_err
  );

  // FIFO side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, in_latency, out_valid, out_data, proto_err
  );
endinterface

// File: rtl/channel_rx_fifo.sv
// rtl/channel_rx_fifo.sv - receive-side channel FIFO with latency report and handshake checker
module channel_rx_fifo #(
  parameter int N                   = 10,
  parameter int LATENCY_COUNT_WIDTH = 6,
  parameter int DEPTH               = 8
) (
  input logic              clk,
  input logic              rst,
  channel_rx_fifo_if.slave bus
);
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int LW      = LATENCY_COUNT_WIDTH;
  localparam int LAT_MAX = (1 << LW) - 1;

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [LW-1:0] r_latency;
  logic          r_pend;
  logic [N-1:0]  r_hold;
  logic          r_proto_err;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic [LW-1:0] w_latency_nxt;

  // Ready comes only from registered count (and rst), never from in_valid/out_ready.
  assign w_ready = !rst && (r_count < CW'(DEPTH));
  assign w_push  = bus.in_valid && w_ready;
  assign w_pop   = (r_count != '0) && bus.out_ready;

  assign bus.in_ready   = w_ready;
  assign bus.out_valid  = (r_count != '0);
  assign bus.out_data   = r_mem[r_rd_ptr];
  assign bus.in_latency = r_latency;
  assign bus.proto_err  = r_proto_err;

  // Next occupancy and the saturated/zero-extended latency report derived from it.
  always_comb begin
    w_count_nxt   = r_count;
    w_latency_nxt = '0;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
    if (int'(w_count_nxt) > LAT_MAX) begin
      w_latency_nxt = LW'(LAT_MAX);
    end else begin
      w_latency_nxt = LW'(w_count_nxt);
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // Pointers, occupancy and latency register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_latency <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count   <= w_count_nxt;
      r_latency <= w_latency_nxt;
    end
  end

  // Sender must hold valid and data stable once it has been stalled; violations stick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_hold      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (r_pend && (!bus.in_valid || (bus.in_data != r_hold))) begin
        r_proto_err <= 1'b1;
      end
      if (bus.in_valid && !w_ready) begin
        r_pend <= 1'b1;
        r_hold <= bus.in_data;
      end else begin
        r_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_channel_rx_fifo.sv
// tb/tb_channel_rx_fifo.sv - directed self-checking bench for channel_rx_fifo
module tb_channel_rx_fifo;
  localparam int N     = 10;
  localparam int LW    = 6;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  channel_rx_fifo_if #(.N(N), .LATENCY_COUNT_WIDTH(LW)) bus ();

  channel_rx_fifo #(.N(N), .LATENCY_COUNT_WIDTH(LW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_latency", 32'(bus.in_latency), 32'd0);
    check("rst_proto", 32'(bus.proto_err), 32'd0);
  endtask

  task automatic fill8();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 10'(k);
      step();
    end
    check("fill8_ready", 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int sent;
    int recvd;
    int cyc;
    logic exp_ready;
    logic push;
    logic pop;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state while rst is held
    #2;
    check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    check("hold_out_valid", 32'(bus.out_valid), 32'd0);
    check("hold_latency", 32'(bus.in_latency), 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_latency", 32'(bus.in_latency), 32'd0);
      check("idle_proto", 32'(bus.proto_err), 32'd0);
    end

    // Back-to-back stream with consumer always ready
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 10'(k);
      step();
      check("stream_valid", 32'(bus.out_valid), 32'd1);
      check("stream_data", 32'(bus.out_data), 32'(k));
      check("stream_latency", 32'(bus.in_latency), 32'd1);
      check("stream_ready", 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b0;
    step();
    check("stream_drained", 32'(bus.out_valid), 32'd0);
    check("stream_lat0", 32'(bus.in_latency), 32'd0);

    // Fill to full, stall the 9th word, single pop frees one slot
    bus.out_ready = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 10'(k);
      step();
      check("fill_latency", 32'(bus.in_latency), 32'(k));
      check("fill_ready", 32'(bus.in_ready), (k < DEPTH) ? 32'd1 : 32'd0);
    end
    bus.in_data = 10'd9;
    step();
    check("full_stall_latency", 32'(bus.in_latency), 32'd8);
    check("full_stall_ready", 32'(bus.in_ready), 32'd0);
    check("legal_stall_proto", 32'(bus.proto_err), 32'd0);
    check("full_head", 32'(bus.out_data), 32'd1);
    bus.out_ready = 1'b1;
    step();
    check("pop_latency", 32'(bus.in_latency), 32'd7);
    check("pop_ready", 32'(bus.in_ready), 32'd1);
    check("pop_head", 32'(bus.out_data), 32'd2);
    bus.out_ready = 1'b0;
    step();
    check("ninth_latency", 32'(bus.in_latency), 32'd8);
    check("ninth_ready", 32'(bus.in_ready), 32'd0);
    check("ninth_proto", 32'(bus.proto_err), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int e = 2; e <= 9; e++) begin
      check("drain_valid", 32'(bus.out_valid), 32'd1);
      check("drain_data", 32'(bus.out_data), 32'(e));
      step();
    end
    check("drain_empty", 32'(bus.out_valid), 32'd0);

    // Wrap-around with random consumer backpressure, scoreboarded
    sent  = 0;
    recvd = 0;
    cyc   = 0;
    while (recvd < 20 && cyc < 400) begin
      bus.in_valid  = (sent < 20);
      bus.in_data   = 10'(32'h100 + sent);
      bus.out_ready = 1'($urandom_range(0, 1));
      exp_ready = (q.size() < DEPTH);
      check("wrap_ready", 32'(bus.in_ready), 32'(exp_ready));
      check("wrap_valid", 32'(bus.out_valid), (q.size() > 0) ? 32'd1 : 32'd0);
      if (q.size() > 0) check("wrap_data", 32'(bus.out_data), 32'(q[0]));
      push = bus.in_valid && exp_ready;
      pop  = (q.size() > 0) && bus.out_ready;
      step();
      if (pop) begin
        void'(q.pop_front());
        recvd++;
      end
      if (push) begin
        q.push_back(32'h100 + sent);
        sent++;
      end
      check("wrap_latency", 32'(bus.in_latency), 32'(q.size()));
      cyc++;
    end
    check("wrap_all_received", 32'(recvd), 32'd20);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();

    // Data changed while stalled
    pulse_reset();
    fill8();
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h155;
    step();
    check("viol_a_before", 32'(bus.proto_err), 32'd0);
    bus.in_data = 10'h0AA;
    step();
    check("viol_a_set", 32'(bus.proto_err), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("viol_a_sticky", 32'(bus.proto_err), 32'd1);

    // Valid dropped while stalled
    pulse_reset();
    fill8();
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h155;
    step();
    check("viol_b_before", 32'(bus.proto_err), 32'd0);
    bus.in_valid = 1'b0;
    step();
    check("viol_b_set", 32'(bus.proto_err), 32'd1);
    pulse_reset();

    // Asynchronous reset with five words queued
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 10'(32'h2A0 + k);
      step();
    end
    bus.in_valid = 1'b0;
    check("q5_latency", 32'(bus.in_latency), 32'd5);
    #3;
    rst = 1'b1;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_in_ready", 32'(bus.in_ready), 32'd0);
    check("async_latency", 32'(bus.in_latency), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("after_async_ready", 32'(bus.in_ready), 32'd1);
    check("after_async_empty", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h3C0;
    step();
    bus.in_valid = 1'b0;
    check("post_reset_valid", 32'(bus.out_valid), 32'd1);
    check("post_reset_data", 32'(bus.out_data), 32'h3C0);
    check("post_reset_latency", 32'(bus.in_latency), 32'd1);
    bus.out_ready = 1'b1;
    step();
    check("post_reset_drained", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
